// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and encodings for the iterative divider.
//   div_state_e      : divider FSM state encoding (free, by-zero, on, end)
//   DIV_START/STOP   : start request levels seen on start_i
//   DIV_RESULT_*     : ready_o levels
//   EXE_DIV(U)_OP    : execute-stage opcodes routed to the divider
//   REG_BUS_W/DOUBLE_REG_BUS_W : register bus widths reused for operands/result
package div_unit_pkg;

   localparam int REG_BUS_W        = 32;
   localparam int DOUBLE_REG_BUS_W = 2 * REG_BUS_W;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
//   signed_div_i : 1 = signed DIV, 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request level, held until ready_o is seen
//   annul_i      : cancel an in-flight division
//   result_o     : {remainder, quotient}
//   ready_o      : result_o valid
// master = execute stage, slave = divider.
interface div_unit_if #(
   parameter int DATA_W = 32
);
   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem      : current partial remainder (always < divisor)
//   next_bit : next dividend bit shifted into the partial remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtraction (restored if negative)
//   q_bit    : quotient bit produced by this iteration
// With DIV_EARLY_OUT_EN defined, it also provides the leading-zero count of
// lz_src on lz (DATA_W when lz_src is zero).
module div_step #(
   parameter int DATA_W = 32
`ifdef DIV_EARLY_OUT_EN
   , parameter int CNT_W = 6
`endif
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              next_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
`ifdef DIV_EARLY_OUT_EN
   , input  logic [DATA_W-1:0] lz_src
   , output logic [CNT_W-1:0]  lz
`endif
);

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;
   logic            unused_diff_msb;

   always_comb begin
      shifted  = {rem, next_bit};
      diff     = shifted - {1'b0, divisor};
      q_bit    = (shifted >= {1'b0, divisor});
      // Either branch is < divisor, so the top bit is always zero.
      rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
   end

   assign unused_diff_msb = diff[DATA_W];

`ifdef DIV_EARLY_OUT_EN
   function automatic logic [CNT_W-1:0] count_lz(input logic [DATA_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = CNT_W'(DATA_W);
      // Later (higher) set bits overwrite earlier ones, leaving the MSB's count.
      for (int i = 0; i < DATA_W; i++) begin
         if (v[i]) n = CNT_W'(DATA_W - 1 - i);
      end
      return n;
   endfunction

   assign lz = count_lz(lz_src);
`endif

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU unit for the execute stage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : div_unit_if.slave (operands, start/annul, {remainder, quotient}, ready)
// One restoring step per cycle, 32 steps per division; ready_o rises one
// cycle after the FSM reaches END and stays while start_i is held.
// Optional feature macro: DIV_EARLY_OUT_EN -- skips leading zero dividend bits
// (one pre-shift cycle, then 32-lz steps); results are unchanged.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int CNT_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   div_unit_if.slave        bus
);

   div_state_e             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [DATA_W-1:0]      rem_reg, rem_next;      // partial remainder
   logic [DATA_W-1:0]      quo_reg, quo_next;      // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0]      divisor_reg, divisor_next;
   logic                   neg_quot_reg, neg_quot_next;
   logic                   neg_rem_reg, neg_rem_next;
   logic [2*DATA_W-1:0]    result_reg, result_next;
   logic                   ready_reg, ready_next;

   logic [DATA_W-1:0]      op1_abs, op2_abs;
   logic [DATA_W-1:0]      step_rem;
   logic                   step_q;
   logic [DATA_W-1:0]      quo_shifted;

`ifdef DIV_EARLY_OUT_EN
   logic                   prep_reg, prep_next;    // first ON cycle: normalise dividend
   logic [CNT_W-1:0]       lz;
`endif

   div_step #(
      .DATA_W(DATA_W)
`ifdef DIV_EARLY_OUT_EN
      , .CNT_W(CNT_W)
`endif
   ) u_step (
      .rem      (rem_reg),
      .next_bit (quo_reg[DATA_W-1]),
      .divisor  (divisor_reg),
      .rem_next (step_rem),
      .q_bit    (step_q)
`ifdef DIV_EARLY_OUT_EN
      , .lz_src (quo_reg)
      , .lz     (lz)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= DIV_FREE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         divisor_reg  <= '0;
         neg_quot_reg <= 1'b0;
         neg_rem_reg  <= 1'b0;
         result_reg   <= '0;
         ready_reg    <= DIV_RESULT_NOT_READY;
`ifdef DIV_EARLY_OUT_EN
         prep_reg     <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rem_reg      <= rem_next;
         quo_reg      <= quo_next;
         divisor_reg  <= divisor_next;
         neg_quot_reg <= neg_quot_next;
         neg_rem_reg  <= neg_rem_next;
         result_reg   <= result_next;
         ready_reg    <= ready_next;
`ifdef DIV_EARLY_OUT_EN
         prep_reg     <= prep_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rem_next      = rem_reg;
      quo_next      = quo_reg;
      divisor_next  = divisor_reg;
      neg_quot_next = neg_quot_reg;
      neg_rem_next  = neg_rem_reg;
      result_next   = result_reg;
      ready_next    = ready_reg;
`ifdef DIV_EARLY_OUT_EN
      prep_next     = prep_reg;
`endif

      // Magnitudes only for signed requests; 0x80000000 maps onto itself,
      // which is the correct unsigned magnitude.
      op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
      op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
      quo_shifted = {quo_reg[DATA_W-2:0], step_q};

      unique case (state_reg)
         DIV_FREE: begin
            result_next = '0;
            ready_next  = DIV_RESULT_NOT_READY;
            if (bus.start_i == DIV_START && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_next = DIV_BY_ZERO;
               end else begin
                  rem_next      = '0;
                  quo_next      = op1_abs;
                  divisor_next  = op2_abs;
                  neg_quot_next = bus.signed_div_i &
                                  (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                  neg_rem_next  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                  cnt_next      = '0;
                  state_next    = DIV_ON;
`ifdef DIV_EARLY_OUT_EN
                  prep_next     = 1'b1;
`endif
               end
            end
         end

         DIV_BY_ZERO: begin
            rem_next = '0;
            quo_next = '0;
            state_next = bus.annul_i ? DIV_FREE : DIV_END;
         end

         DIV_ON: begin
            if (bus.annul_i) begin
               state_next  = DIV_FREE;
               result_next = '0;
               ready_next  = DIV_RESULT_NOT_READY;
`ifdef DIV_EARLY_OUT_EN
               prep_next   = 1'b0;
            end else if (prep_reg) begin
               prep_next = 1'b0;
               if (quo_reg == '0) begin
                  rem_next   = '0;
                  state_next = DIV_END;
               end else begin
                  // Leading zero bits would only produce zero quotient bits.
                  quo_next = quo_reg << lz;
                  cnt_next = lz;
               end
`endif
            end else begin
               rem_next = step_rem;
               quo_next = quo_shifted;
               cnt_next = cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                  // Final step: apply sign correction on the way into END.
                  quo_next   = neg_quot_reg ? -quo_shifted : quo_shifted;
                  rem_next   = neg_rem_reg  ? -step_rem    : step_rem;
                  state_next = DIV_END;
               end
            end
         end

         DIV_END: begin
            if (bus.annul_i || bus.start_i == DIV_STOP) begin
               state_next  = DIV_FREE;
               result_next = '0;
               ready_next  = DIV_RESULT_NOT_READY;
            end else begin
               result_next = {rem_reg, quo_reg};
               ready_next  = DIV_RESULT_READY;
            end
         end

         default: state_next = DIV_FREE;
      endcase
   end

   assign bus.result_o = result_reg;
   assign bus.ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector scoreboard bench for div_unit (default build).
// The driver pushes the expected result and ready cycle for each accepted
// request; an independent monitor compares whenever ready_o rises, and checks
// result hold while start_i is held and clearing once start_i drops.
module tb_div_unit;

   typedef struct {
      string       name;
      logic [63:0] res;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   div_unit_if #(.DATA_W(32)) bus ();

   div_unit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples just after each rising edge, so inputs seen are those of that edge.
   initial begin
      logic        prev_ready;
      logic [63:0] held;
      exp_t        e;
      prev_ready = 1'b0;
      held = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            prev_ready = 1'b0;
         end else begin
            if (prev_ready && !bus.start_i) begin
               check("drop_clears", {63'(bus.result_o != 0), bus.ready_o}, 64'd0);
            end else if (bus.ready_o && prev_ready) begin
               check("hold", bus.result_o, held);
            end else if (bus.ready_o) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ready", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check({e.name, "_result"}, bus.result_o, e.res);
                  check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                  $display("[TB] %s result=%h at cycle %0d", e.name, bus.result_o, cyc);
               end
               held = bus.result_o;
            end
            prev_ready = bus.ready_o;
         end
      end
   end

   // Wait for ready, hold start two more cycles, then drop it for one cycle.
   task automatic finish_div(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (bus.ready_o) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
      repeat (2) @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic issue(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res, input int lat,
                        input bit expect_it);
      exp_t e;
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      if (expect_it) begin
         e.name = name;
         e.res  = res;
         e.cyc  = cyc + 1 + lat;   // accept edge is the next rising edge
         exp_q.push_back(e);
      end
   endtask

   task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res, input int lat);
      issue(name, sgn, a, b, res, lat, 1'b1);
      finish_div(name);
   endtask

   initial begin
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_result", bus.result_o, 64'd0);
      check("reset_ready", 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div("divu_10_3",       1'b0, 32'd10,         32'd3,          64'h00000001_00000003, 33);
      run_div("div_m7_2",        1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33);
      run_div("div_7_m2",        1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
      run_div("div_m100_m7",     1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33);
      run_div("div_by_zero_s",   1'b1, 32'd5,          32'd0,          64'h0,                 2);
      run_div("div_by_zero_u",   1'b0, 32'd5,          32'd0,          64'h0,                 2);
      run_div("div_overflow",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
      run_div("divu_max_1",      1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33);
      run_div("divu_max_max",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33);
      run_div("divu_zero_dvd",   1'b0, 32'd0,          32'd5,          64'h0,                 33);
      run_div("divu_hex",        1'b0, 32'h12345678,   32'h00001000,   64'h00000678_00012345, 33);

      // Annul during ON at accept+10, then an immediate new request.
      issue("annulled", 1'b0, 32'd1000, 32'd3, 64'h0, 0, 1'b0);
      repeat (9) @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i   = 1'b0;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      begin
         exp_t e;
         e.name = "after_annul_100_7";
         e.res  = 64'h00000002_0000000E;
         e.cyc  = cyc + 1 + 33;
         exp_q.push_back(e);
      end
      finish_div("after_annul_100_7");

      // Reset in the middle of a division.
      issue("rst_mid", 1'b0, 32'd10, 32'd3, 64'h0, 0, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      check("rst_mid_result", bus.result_o, 64'd0);
      check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      run_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

      // Reset while a result is being presented.
      issue("rst_end", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 33, 1'b1);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1'b1;
         end
         if (!seen) check("rst_end_timeout", 64'd0, 64'd1);
      end
      rst = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      check("rst_end_result", bus.result_o, 64'd0);
      check("rst_end_ready", 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit divider serving the execute stage for DIV/DIVU.
- EX issues operands and a start pulse, and holds the pipeline stalled.
- The unit computes quotient and remainder bit-serially: one radix-2 restoring step per cycle.
- It returns {remainder, quotient}, which EX writes to HI/LO.

Parameters:
- DATA_W, 32, operand width; must match RegBus.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = DIV (two's complement); 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request from EX; level, held until ready_o is seen.
- annul_i  in  1  cancel an in-flight division (flush/exception); priority over start_i.
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset: rst sampled high at a clock edge gives state=FREE, result_o=0, ready_o=0, counter=0, internal dividend/divisor registers=0.
- Reset mid-division aborts with no residue.
- All outputs are registered.

States: FREE, BY_ZERO, ON, END.

FREE:
- start_i=1 and annul_i=0 with opdata2_i==0: go to BY_ZERO.
- start_i=1 and annul_i=0 with nonzero divisor: latch |opdata1_i| and |opdata2_i|, latch the sign flags, clear counter, go to ON.
  - Absolute values are taken only when signed_div_i=1.
  - Operands are sampled only in this cycle; later changes are ignored.
- Otherwise stay in FREE; ready_o=0, result_o=0.

BY_ZERO:
- Next state END, with result 64'h0.

ON:
- Each cycle performs one step: shift the partial remainder left by 1, bring in the next dividend MSB, trial-subtract the divisor.
  - If the result is non-negative, keep it and set quotient bit = 1.
  - Otherwise restore and set quotient bit = 0.
- Counter increments each step. After the 32nd step, go to END.
- In the transition to END, fix signs (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- annul_i=1 in ON: go to FREE next cycle, ready_o stays 0, result discarded.

END:
- ready_o=1; result_o holds the result.
- Stay while start_i=1.
- start_i=0: go to FREE, clearing ready_o and result_o.

Latency:
- start_i accepted at edge N.
- Nonzero divisor: ready_o=1 from edge N+33 (32 ON cycles + END).
- Zero divisor: ready_o=1 from edge N+2.

Boundary cases:
- 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. No trap.
- Dividend 0 follows the normal path: 32 cycles, result 0.
- annul_i in FREE or END forces FREE and clears outputs.
- start_i held high through END does not retrigger; a new division requires start_i to drop for at least one cycle.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined:
  - On entry to ON, the leading-zero count of |dividend| is computed and the dividend is pre-shifted left by that count.
  - The counter is preloaded to the same count, so ON lasts 32-lz cycles, minimum 1.
  - Dividend==0 goes directly to END in one cycle with result 0.
  - Results are bit-identical to the non-feature build.
- When undefined: fixed 32-cycle ON phase as above.

Decomposition:
- Add to defines.v:
  - State encodings DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - EXE_DIV_OP/EXE_DIVU_OP, if not already present.
  - Widths reuse RegBus and DoubleRegBus.
- Natural sub-module: div_step, a combinational single iteration (partial remainder and divisor in; next partial remainder and quotient bit out). It is instantiated once.
- Under DIV_EARLY_OUT_EN, a leading-zero counter function also belongs in div_step's file.

Test Plan:
- Unsigned 10/3, start at edge N: ready_o=1 at N+33, result_o=64'h00000001_00000003. Output holds while start_i=1; ready_o=0 one cycle after start_i drops.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o=64'hFFFFFFFF_FFFFFFFD. Also check 7/-2, giving 64'h00000001_FFFFFFFD.
- Divide-by-zero 5/0 (signed and unsigned): ready_o=1 at N+2, result_o=0.
- annul_i pulsed at N+10 during ON: FREE at N+11, ready_o never asserts. An immediate new 100/7 completes correctly with 64'h00000002_0000000E.
- Overflow 0x80000000/0xFFFFFFFF signed gives 64'h00000000_80000000. Unsigned 0xFFFFFFFF/1 gives 64'h00000000_FFFFFFFF.
- Mid-operation behaviour:
  - rst asserted at N+20: all outputs 0 next edge, state FREE.
  - With DIV_EARLY_OUT_EN, 10/3 reaches ready_o at N+1+(32-28)+1 = N+6, with the same result as the fixed-latency build.
